// File: rtl/magic_nor_sequencer_if.sv
// Host/ROM/crossbar bundle for magic_nor_sequencer.
// master: host side (start/abort/prog_len), ROM data return and crossbar ready.
// slave : the sequencer (ROM address, crossbar strobes and cell indices, status).
interface magic_nor_sequencer_if #(
    parameter int unsigned CELL_W = 5,
    parameter int unsigned PC_W   = 7
);
    localparam int unsigned ROM_W = 2 + 3 * CELL_W;

    logic              start;
    logic              abort;
    logic [PC_W-1:0]   prog_len;
    logic [PC_W-1:0]   rom_addr;
    logic [ROM_W-1:0]  rom_data;
    logic              xb_ready;
    logic              xb_init;
    logic              xb_eval;
    logic              xb_nor2;
    logic [CELL_W-1:0] xb_src_a;
    logic [CELL_W-1:0] xb_src_b;
    logic [CELL_W-1:0] xb_dst;
    logic              busy;
    logic              done;
    logic              err;
    logic [PC_W-1:0]   op_count;

    modport master (
        output start, abort, prog_len, rom_data, xb_ready,
        input  rom_addr, xb_init, xb_eval, xb_nor2, xb_src_a, xb_src_b, xb_dst,
               busy, done, err, op_count
    );

    modport slave (
        input  start, abort, prog_len, rom_data, xb_ready,
        output rom_addr, xb_init, xb_eval, xb_nor2, xb_src_a, xb_src_b, xb_dst,
               busy, done, err, op_count
    );
endinterface

// File: rtl/magic_nor_sequencer.sv
// Sequences inv1/nor2 micro-ops from a synchronous program ROM onto one ReRAM
// crossbar row as MAGIC operations: INIT (dst forced to LRS) then EVAL.
// Ports: clk, rst_n (async active-low), bus (magic_nor_sequencer_if.slave):
//   start/abort/prog_len in, rom_addr out / rom_data in, xb_ready in,
//   xb_init/xb_eval/xb_nor2/xb_src_a/xb_src_b/xb_dst out, busy/done/err/op_count out.
module magic_nor_sequencer #(
    parameter int unsigned CELL_W   = 5,
    parameter int unsigned PC_W     = 7,
    parameter int unsigned INIT_CYC = 1,
    parameter int unsigned EVAL_CYC = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    magic_nor_sequencer_if.slave  bus
);
    localparam int unsigned ROM_W   = 2 + 3 * CELL_W;
    localparam int unsigned MAX_CYC = (INIT_CYC > EVAL_CYC) ? INIT_CYC : EVAL_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_NOR2 = 2'b10;
    localparam logic [1:0] OP_END  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_INIT, S_EVAL, S_ADVANCE, S_DONE
    } state_t;

    state_t            state, state_d;
    logic [PC_W-1:0]   pc, pc_d;
    logic [PC_W-1:0]   len, len_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [PC_W-1:0]   op_count, op_count_d;
    logic              err, err_d;
    logic              nor2, nor2_d;
    logic [CELL_W-1:0] src_a, src_a_d, src_b, src_b_d, dst, dst_d;
    logic              init_q, eval_q, busy_q, done_q;

    // ROM word fields: {op, src_a, src_b, dst}
    logic [1:0]        f_op;
    logic [CELL_W-1:0] f_a, f_b, f_dst;
    assign f_op  = bus.rom_data[ROM_W-1 -: 2];
    assign f_a   = bus.rom_data[3*CELL_W-1 -: CELL_W];
    assign f_b   = bus.rom_data[2*CELL_W-1 -: CELL_W];
    assign f_dst = bus.rom_data[CELL_W-1:0];

    // Next-state and datapath update
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        len_d      = len;
        cnt_d      = cnt;
        op_count_d = op_count;
        err_d      = err;
        nor2_d     = nor2;
        src_a_d    = src_a;
        src_b_d    = src_b;
        dst_d      = dst;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    len_d      = bus.prog_len;
                    op_count_d = '0;
                    err_d      = 1'b0;
                    pc_d       = '0;
                    state_d    = (bus.prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                nor2_d  = (f_op == OP_NOR2);
                src_a_d = f_a;
                src_b_d = f_b;
                dst_d   = f_dst;
                cnt_d   = '0;
                if (f_op == OP_END) begin
                    state_d = S_DONE;
                end else if (f_op == OP_NOP) begin
                    state_d = S_ADVANCE;
                end else if (f_dst == f_a || (f_op == OP_NOR2 && f_dst == f_b)) begin
                    // destination overlapping a source would destroy the operand
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (bus.xb_ready) begin
                    if (cnt == CNT_W'(INIT_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = S_EVAL;
                    end else begin
                        cnt_d = CNT_W'(cnt + 1'b1);
                    end
                end
            end
            S_EVAL: begin
                if (bus.xb_ready) begin
                    if (cnt == CNT_W'(EVAL_CYC - 1)) begin
                        cnt_d      = '0;
                        op_count_d = PC_W'(op_count + 1'b1);
                        state_d    = S_ADVANCE;
                    end else begin
                        cnt_d = CNT_W'(cnt + 1'b1);
                    end
                end
            end
            S_ADVANCE: begin
                pc_d    = PC_W'(pc + 1'b1);
                state_d = (pc_d == len) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // abort wins over everything and leaves counters/flags untouched
        if (bus.abort) begin
            state_d    = S_IDLE;
            pc_d       = pc;
            len_d      = len;
            op_count_d = op_count;
            err_d      = err;
            cnt_d      = '0;
        end
    end

    // State, datapath and registered outputs (strobes decoded from next state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            len      <= '0;
            cnt      <= '0;
            op_count <= '0;
            err      <= 1'b0;
            nor2     <= 1'b0;
            src_a    <= '0;
            src_b    <= '0;
            dst      <= '0;
            init_q   <= 1'b0;
            eval_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            len      <= len_d;
            cnt      <= cnt_d;
            op_count <= op_count_d;
            err      <= err_d;
            nor2     <= nor2_d;
            src_a    <= src_a_d;
            src_b    <= src_b_d;
            dst      <= dst_d;
            init_q   <= (state_d == S_INIT);
            eval_q   <= (state_d == S_EVAL);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign bus.rom_addr = pc;
    assign bus.xb_init  = init_q;
    assign bus.xb_eval  = eval_q;
    assign bus.xb_nor2  = nor2;
    assign bus.xb_src_a = src_a;
    assign bus.xb_src_b = src_b;
    assign bus.xb_dst   = dst;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err;
    assign bus.op_count = op_count;
endmodule
